// File: rtl/sinc3_pkg.sv
// -----------------------------------------------------------------------------
// sinc3_pkg
// Definitions shared by the sinc3 frame packer and its output FIFO.
//   SINC3_W  width of the unsigned sinc3 decimator output
//   OUT_W    width of the signed, aligned output sample
//   D1_W     width of the offset-removed intermediate (one sign bit added)
//   state_t  frame FSM states
//   calc_k   log2 of the CIC mid-scale offset for a decimation select M
// -----------------------------------------------------------------------------
package sinc3_pkg;

   localparam int SINC3_W = 25;
   localparam int OUT_W   = 16;
   localparam int D1_W    = SINC3_W + 1;

   typedef enum logic {
      IDLE = 1'b0,
      FILL = 1'b1
   } state_t;

   // M above 7 is clamped to 7; K = 3*Meff + 2 (range 2..23).
   function automatic logic [4:0] calc_k(input logic [3:0] m);
      logic [3:0] meff;
      meff = (m > 4'd7) ? 4'd7 : m;
      return ({1'b0, meff} * 5'd3) + 5'd2;
   endfunction

endpackage

// File: rtl/frame_fifo.sv
// -----------------------------------------------------------------------------
// frame_fifo
// Synchronous FIFO with a registered first-word-fall-through head.
//   clk      rising-edge clock
//   rst      asynchronous active-high reset (empties the FIFO)
//   i_push   write request; accepted when not full, or when full with a pop
//   i_wdata  word to write
//   i_pop    read request; ignored while empty
//   o_rdata  head word, registered, stable until popped
//   o_valid  head word present
//   o_full   FIFO holds DEPTH words
//   o_level  number of stored words (head included)
// -----------------------------------------------------------------------------
module frame_fifo
   import sinc3_pkg::*;
#(
   parameter int WIDTH = OUT_W + 1,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_wdata,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_rdata,
   output logic                     o_valid,
   output logic                     o_full,
   output logic [$clog2(DEPTH):0]   o_level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [LW-1:0]    r_count;
   logic [WIDTH-1:0] r_head;
   logic             r_valid;

   logic             w_pop_ok;
   logic             w_push_ok;
   logic             w_full;
   logic [AW-1:0]    w_wptr_nxt;
   logic [AW-1:0]    w_rptr_nxt;
   logic [LW-1:0]    w_count_nxt;
   logic [WIDTH-1:0] w_head_nxt;

   assign w_full      = (r_count == LW'(DEPTH));
   assign w_pop_ok    = i_pop & (r_count != '0);
   // A full FIFO still takes a word when the head leaves in the same cycle.
   assign w_push_ok   = i_push & (~w_full | w_pop_ok);
   assign w_wptr_nxt  = w_push_ok ? r_wptr + 1'b1 : r_wptr;
   assign w_rptr_nxt  = w_pop_ok  ? r_rptr + 1'b1 : r_rptr;
   assign w_count_nxt = r_count + LW'(w_push_ok) - LW'(w_pop_ok);

   // Next head: the word being written lands directly in the head register
   // when it is the one the read pointer will point at (empty FIFO case).
   always_comb begin
      w_head_nxt = r_head;
      if (w_count_nxt != '0) begin
         if (w_push_ok && (r_wptr == w_rptr_nxt)) begin
            w_head_nxt = i_wdata;
         end else begin
            w_head_nxt = r_mem[w_rptr_nxt];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_mem[r_wptr] <= i_wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_head  <= '0;
         r_valid <= 1'b0;
      end else begin
         r_wptr  <= w_wptr_nxt;
         r_rptr  <= w_rptr_nxt;
         r_count <= w_count_nxt;
         r_head  <= w_head_nxt;
         r_valid <= (w_count_nxt != '0);
      end
   end

   assign o_rdata = r_head;
   assign o_valid = r_valid;
   assign o_full  = w_full;
   assign o_level = r_count;

endmodule

// File: rtl/sinc3_frame_packer.sv
// -----------------------------------------------------------------------------
// sinc3_frame_packer
// Removes the sinc3 mid-scale offset, aligns/saturates each decimated sample
// to 16-bit signed and packs the words into FRAME_LEN-word frames in a FIFO.
//   mclk          clock, rising edge
//   rst           asynchronous active-high reset
//   en            capture enable, honoured only at frame boundaries
//   M             decimation select (values above 7 act as 7)
//   sample_in     unsigned sinc3 output
//   sample_valid  one-cycle strobe per new sample
//   out_data      signed output word
//   out_last      last word of a frame
//   out_valid     out_data/out_last valid
//   out_ready     consumer ready
//   fifo_level    words stored in the FIFO
//   ovf           sticky: a word was dropped on a full FIFO
//   ovf_clr       clears ovf (a simultaneous drop wins)
//   busy          frame FSM is in FILL
// -----------------------------------------------------------------------------
module sinc3_frame_packer
   import sinc3_pkg::*;
#(
   parameter int FRAME_LEN  = 256,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          mclk,
   input  logic                          rst,
   input  logic                          en,
   input  logic [3:0]                    M,
   input  logic [SINC3_W-1:0]            sample_in,
   input  logic                          sample_valid,
   output logic [OUT_W-1:0]              out_data,
   output logic                          out_last,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          ovf,
   input  logic                          ovf_clr,
   output logic                          busy
);

   localparam int IW    = $clog2(FRAME_LEN);
   localparam int ALN_W = D1_W + 15;

   localparam logic signed [ALN_W-1:0] SAT_HI = ALN_W'(32767);
   localparam logic signed [ALN_W-1:0] SAT_LO = -SAT_HI - 1;

   // Align the offset-removed sample so that 2^K maps to 2^15, then clamp.
   // Right shifts are arithmetic (floor toward minus infinity).
   function automatic logic signed [OUT_W-1:0] align_sat(
      input logic signed [D1_W-1:0] d,
      input logic [4:0]             k
   );
      logic signed [ALN_W-1:0] w;
      w = {{15{d[D1_W-1]}}, d};
      if (k > 5'd15) begin
         w = w >>> (k - 5'd15);
      end else begin
         w = w <<< (5'd15 - k);
      end
      if (w > SAT_HI) begin
         return 16'sh7fff;
      end else if (w < SAT_LO) begin
         return 16'sh8000;
      end
      return w[OUT_W-1:0];
   endfunction

   logic [4:0]                w_k;
   logic signed [D1_W-1:0]    w_offset;
   logic signed [D1_W-1:0]    w_d1;

   logic signed [D1_W-1:0]    r_d1_p1;
   logic                      r_vld_p1;
   logic signed [OUT_W-1:0]   r_q_p2;
   logic                      r_vld_p2;

   state_t                    r_state;
   state_t                    w_state_nxt;
   logic [IW-1:0]             r_idx;
   logic [IW-1:0]             w_idx_nxt;
   logic                      w_push;
   logic                      w_last;
   logic                      w_drop;
   logic                      w_room;
   logic                      r_ovf;

   logic [OUT_W:0]            w_fifo_rdata;
   logic                      w_fifo_valid;
   logic                      w_fifo_full;

   assign w_k      = calc_k(M);
   assign w_offset = D1_W'(1) << w_k;
   assign w_d1     = $signed({1'b0, sample_in}) - w_offset;

   // ---- stage p1: offset removal ----
   always_ff @(posedge mclk) begin
      if (sample_valid) begin
         r_d1_p1 <= w_d1;
      end
   end

   // ---- stage p2: alignment and saturation ----
   always_ff @(posedge mclk) begin
      if (r_vld_p1) begin
         r_q_p2 <= align_sat(r_d1_p1, w_k);
      end
   end

   always_ff @(posedge mclk or posedge rst) begin
      if (rst) begin
         r_vld_p1 <= 1'b0;
         r_vld_p2 <= 1'b0;
      end else begin
         r_vld_p1 <= sample_valid;
         r_vld_p2 <= r_vld_p1;
      end
   end

   // ---- frame FSM: acts on the p2 write strobe ----
   assign w_room = ~w_fifo_full | (w_fifo_valid & out_ready);

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_push      = 1'b0;
      w_last      = 1'b0;
      w_drop      = 1'b0;
      if (r_vld_p2 && ((r_state == FILL) || en)) begin
         if (w_room) begin
            w_push = 1'b1;
            if (r_idx == IW'(FRAME_LEN - 1)) begin
               w_last      = 1'b1;
               w_idx_nxt   = '0;
               w_state_nxt = en ? FILL : IDLE;
            end else begin
               w_idx_nxt   = r_idx + 1'b1;
               w_state_nxt = FILL;
            end
         end else begin
            // Dropped words leave the index untouched so frames stay whole.
            w_drop = 1'b1;
         end
      end
   end

   always_ff @(posedge mclk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_ovf   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         if (w_drop) begin
            r_ovf <= 1'b1;
         end else if (ovf_clr) begin
            r_ovf <= 1'b0;
         end
      end
   end

   frame_fifo #(
      .WIDTH (OUT_W + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (mclk),
      .rst     (rst),
      .i_push  (w_push),
      .i_wdata ({w_last, r_q_p2}),
      .i_pop   (out_ready),
      .o_rdata (w_fifo_rdata),
      .o_valid (w_fifo_valid),
      .o_full  (w_fifo_full),
      .o_level (fifo_level)
   );

   assign out_data  = w_fifo_rdata[OUT_W-1:0];
   assign out_last  = w_fifo_rdata[OUT_W];
   assign out_valid = w_fifo_valid;
   assign ovf       = r_ovf;
   assign busy      = (r_state == FILL);

endmodule

// File: tb/tb_sinc3_frame_packer.sv
module tb_sinc3_frame_packer;

   localparam int FL = 4;
   localparam int FD = 16;

   logic               mclk = 1'b0;
   logic               rst;
   logic               en;
   logic [3:0]         M;
   logic [24:0]        sample_in;
   logic               sample_valid;
   logic signed [15:0] out_data;
   logic               out_last;
   logic               out_valid;
   logic               out_ready;
   logic [4:0]         fifo_level;
   logic               ovf;
   logic               ovf_clr;
   logic               busy;

   sinc3_frame_packer #(.FRAME_LEN(FL), .FIFO_DEPTH(FD)) dut (
      .mclk         (mclk),
      .rst          (rst),
      .en           (en),
      .M            (M),
      .sample_in    (sample_in),
      .sample_valid (sample_valid),
      .out_data     (out_data),
      .out_last     (out_last),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .fifo_level   (fifo_level),
      .ovf          (ovf),
      .ovf_clr      (ovf_clr),
      .busy         (busy)
   );

   always #5 mclk = ~mclk;

   typedef struct {
      int data;
      bit last;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   bit   m_fill = 0;
   int   m_idx  = 0;
   bit   m_ovf  = 0;
   bit   tog_en = 0;

   function automatic void chk(input string nm, input int act, input int expv);
      total++;
      if (act != expv) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, expv);
      end
   endfunction

   function automatic int kval(input int m);
      int meff;
      meff = (m > 7) ? 7 : m;
      return 3 * meff + 2;
   endfunction

   // Reference: (sample - 2^K) scaled by 2^(15-K), floored, clamped to 16 bits.
   function automatic int ref_word(input int s, input int m);
      int k, v, q, div;
      k = kval(m);
      v = s - (1 << k);
      if (k > 15) begin
         div = 1 << (k - 15);
         q = v / div;
         if ((v % div != 0) && (v < 0)) q = q - 1;
      end else begin
         q = v * (1 << (15 - k));
      end
      if (q > 32767) q = 32767;
      if (q < -32768) q = -32768;
      return q;
   endfunction

   function automatic int rsamp(input int m);
      return int'($urandom_range(0, 1 << (kval(m) + 1)));
   endfunction

   // Frame-level model applied to each strobe.
   function automatic void model(input int s);
      exp_t e;
      if (!m_fill && !en) return;
      if (sb.size() >= FD) begin
         m_ovf = 1;
         return;
      end
      e.data = ref_word(s, int'(M));
      e.last = (m_idx == FL - 1);
      sb.push_back(e);
      if (e.last) begin
         m_idx  = 0;
         m_fill = en;
      end else begin
         m_idx  = m_idx + 1;
         m_fill = 1;
      end
   endfunction

   task automatic send(input int s, input int gap);
      @(posedge mclk);
      #1;
      sample_in    = 25'(s);
      sample_valid = 1'b1;
      model(s);
      @(posedge mclk);
      #1;
      sample_valid = 1'b0;
      repeat (gap) @(posedge mclk);
      #1;
   endtask

   task automatic burst(input int n);
      int s;
      for (int i = 0; i < n; i++) begin
         @(posedge mclk);
         #1;
         s            = rsamp(int'(M));
         sample_in    = 25'(s);
         sample_valid = 1'b1;
         model(s);
      end
      @(posedge mclk);
      #1;
      sample_valid = 1'b0;
   endtask

   task automatic drain(input string nm);
      int n;
      n = 0;
      while (sb.size() > 0 && n < 400) begin
         @(posedge mclk);
         n++;
      end
      #1;
      chk(nm, sb.size(), 0);
   endtask

   // Output toggling for the back-pressure phase.
   always @(posedge mclk) begin
      if (tog_en) begin
         #1;
         out_ready = ~out_ready;
      end
   end

   // Monitor: pops the scoreboard on every handshake and checks stall stability.
   bit prev_stall = 0;
   int prev_data  = 0;
   int prev_last  = 0;
   always @(negedge mclk) begin
      exp_t e;
      if (rst) begin
         prev_stall = 0;
      end else begin
         if (prev_stall) begin
            chk("stall_valid", int'(out_valid), 1);
            chk("stall_data", int'(out_data), prev_data);
            chk("stall_last", int'(out_last), prev_last);
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_word: got data=%0d last=%0d expected none",
                        out_data, out_last);
            end else begin
               e = sb.pop_front();
               chk("word_data", int'(out_data), e.data);
               chk("word_last", int'(out_last), int'(e.last));
            end
         end
         prev_stall = out_valid & ~out_ready;
         prev_data  = int'(out_data);
         prev_last  = int'(out_last);
      end
   end

   initial begin
      rst          = 1'b1;
      en           = 1'b0;
      M            = 4'd3;
      sample_in    = '0;
      sample_valid = 1'b0;
      out_ready    = 1'b0;
      ovf_clr      = 1'b0;

      // 1: reset
      repeat (3) @(posedge mclk);
      #1;
      rst = 1'b0;
      @(posedge mclk);
      #1;
      chk("rst_out_data", int'(out_data), 0);
      chk("rst_out_last", int'(out_last), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_fifo_level", int'(fifo_level), 0);
      chk("rst_ovf", int'(ovf), 0);
      chk("rst_busy", int'(busy), 0);

      // 2: offset/alignment with M=3 and first-word latency
      M         = 4'd3;
      en        = 1'b1;
      out_ready = 1'b1;
      send(2048, 0);
      @(posedge mclk);
      #1;
      chk("lat_valid_at2", int'(out_valid), 0);
      @(posedge mclk);
      #1;
      chk("lat_valid_at3", int'(out_valid), 1);
      repeat (2) @(posedge mclk);
      send(3072, 4);
      send(4096, 4);
      en = 1'b0;
      send(0, 4);
      drain("t2_drain");
      chk("t2_busy", int'(busy), 0);

      // 3: right shift with M=7
      M  = 4'd7;
      en = 1'b1;
      send((1 << 23) + 256, 4);
      send((1 << 23) - 512, 4);
      send(1 << 24, 4);
      en = 1'b0;
      send(rsamp(7), 4);
      drain("t3_drain");

      // 4: framing with en falling mid-frame
      M  = 4'($urandom_range(0, 15));
      en = 1'b1;
      for (int i = 0; i < 5; i++) send(rsamp(int'(M)), 4);
      chk("t4_busy_w5", int'(busy), 1);
      en = 1'b0;
      send(rsamp(int'(M)), 4);
      chk("t4_busy_w6", int'(busy), 1);
      send(rsamp(int'(M)), 4);
      send(rsamp(int'(M)), 4);
      chk("t4_busy_w8", int'(busy), 0);
      send(rsamp(int'(M)), 4);
      chk("t4_busy_w9", int'(busy), 0);
      drain("t4_drain");
      repeat (4) @(posedge mclk);
      #1;
      chk("t4_level", int'(fifo_level), 0);

      // 5: overflow
      M         = 4'd3;
      en        = 1'b1;
      out_ready = 1'b0;
      for (int i = 0; i < 18; i++) send(rsamp(3), 3);
      chk("t5_level_full", int'(fifo_level), FD);
      chk("t5_ovf_set", int'(ovf), int'(m_ovf));
      chk("t5_valid", int'(out_valid), 1);
      out_ready = 1'b1;
      drain("t5_drain");
      repeat (2) @(posedge mclk);
      #1;
      chk("t5_level_empty", int'(fifo_level), 0);
      chk("t5_ovf_sticky", int'(ovf), 1);
      ovf_clr = 1'b1;
      @(posedge mclk);
      #1;
      ovf_clr = 1'b0;
      m_ovf   = 0;
      chk("t5_ovf_clr", int'(ovf), int'(m_ovf));

      // 6: back-pressure, then reset mid-frame
      M      = 4'($urandom_range(0, 15));
      tog_en = 1'b1;
      burst(8);
      drain("t6_burst_drain");
      send(rsamp(int'(M)), 3);
      send(rsamp(int'(M)), 3);
      chk("t6_busy_mid", int'(busy), 1);
      tog_en = 1'b0;
      @(posedge mclk);
      #1;
      rst = 1'b1;
      sb.delete();
      m_fill = 0;
      m_idx  = 0;
      m_ovf  = 0;
      #1;
      chk("t6_rst_level", int'(fifo_level), 0);
      chk("t6_rst_busy", int'(busy), 0);
      chk("t6_rst_valid", int'(out_valid), 0);
      repeat (2) @(posedge mclk);
      #1;
      rst       = 1'b0;
      out_ready = 1'b1;
      en        = 1'b1;
      send(rsamp(int'(M)), 4);
      send(rsamp(int'(M)), 4);
      send(rsamp(int'(M)), 4);
      en = 1'b0;
      send(rsamp(int'(M)), 4);
      drain("t6_restart_drain");
      chk("t6_busy_end", int'(busy), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
